// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle datapath controller.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    IEXEC  = 4'd8,
    IWB    = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CL_MEM, CL_R, CL_I, CL_BR, CL_JUMP, CL_ILL
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_ILOGIC = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] BR_EQ  = 2'b00;
  localparam logic [1:0] BR_NE  = 2'b01;
  localparam logic [1:0] BR_GTZ = 2'b10;

  // Control word; the ALU control decoder consumes the aluop field.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] brtype;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier: instruction class and branch flavour.
module mc_opdecode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [1:0] brtype
);

  // Classify the opcode; anything unrecognised is illegal.
  always_comb begin
    op_class = CL_ILL;
    brtype   = BR_EQ;
    case (opcode)
      OP_LW, OP_SW:                     op_class = CL_MEM;
      OP_RTYPE:                         op_class = CL_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: op_class = CL_I;
      OP_BEQ:  begin op_class = CL_BR; brtype = BR_EQ;  end
      OP_BNE:  begin op_class = CL_BR; brtype = BR_NE;  end
      OP_BGTZ: begin op_class = CL_BR; brtype = BR_GTZ; end
      OP_J:                             op_class = CL_JUMP;
      default:                          op_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath control FSM (Moore outputs, outputs forced low in reset).
//
// state  | meaning
// FETCH  | read instruction, PC+4; wait for MemReady
// DECODE | register read, branch target; latch opcode, dispatch
// MEMADR | compute load/store address
// MEMRD  | data read; wait for MemReady
// MEMWB  | write loaded data to rt
// MEMWR  | data write; wait for MemReady
// REXEC  | R-type ALU operation
// RWB    | write ALU result to rd
// IEXEC  | immediate ALU operation
// IWB    | write ALU result to rt
// BRANCH | conditional PC update
// JUMP   | unconditional PC update
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] BrType,
  output logic [1:0] ALUOp,
  output logic       Illegal
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       illegal_q;
  logic [5:0] dec_op;
  op_class_t  dec_class;
  logic [1:0] dec_brtype;
  ctrl_t      ctrl, ctrl_o;

  // The live opcode is only looked at in DECODE; everywhere else the latched copy drives the decoder.
  assign dec_op = (state_q == DECODE) ? Opcode : op_q;

  mc_opdecode u_opdecode (
    .opcode   (dec_op),
    .op_class (dec_class),
    .brtype   (dec_brtype)
  );

  // State, latched opcode and the registered illegal-opcode pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      op_q      <= 6'b000000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == DECODE) && (dec_class == CL_ILL);
      if (state_q == DECODE) op_q <= Opcode;
    end
  end

  // Next-state and per-state control word.
  always_comb begin
    state_d = FETCH;
    ctrl    = '0;
    case (state_q)
      FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = MemReady;
        ctrl.pcwrite = MemReady;
        state_d      = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        case (dec_class)
          CL_MEM:  state_d = MEMADR;
          CL_R:    state_d = REXEC;
          CL_I:    state_d = IEXEC;
          CL_BR:   state_d = BRANCH;
          CL_JUMP: state_d = JUMP;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        state_d      = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = MemReady ? FETCH : MEMWR;
      end
      REXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = RWB;
      end
      RWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      IEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = (op_q == OP_ADDI) ? ALUOP_ADD : ALUOP_ILOGIC;
        state_d      = IWB;
      end
      IWB: ctrl.regwrite = 1'b1;
      BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
        ctrl.brtype      = dec_brtype;
      end
      JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset blanks every output in the very cycle it is sampled.
  assign ctrl_o      = reset ? '0 : ctrl;
  assign PCWrite     = ctrl_o.pcwrite;
  assign PCWriteCond = ctrl_o.pcwritecond;
  assign IorD        = ctrl_o.iord;
  assign MemRead     = ctrl_o.memread;
  assign MemWrite    = ctrl_o.memwrite;
  assign IRWrite     = ctrl_o.irwrite;
  assign MemtoReg    = ctrl_o.memtoreg;
  assign RegDst      = ctrl_o.regdst;
  assign RegWrite    = ctrl_o.regwrite;
  assign ALUSrcA     = ctrl_o.alusrca;
  assign ALUSrcB     = ctrl_o.alusrcb;
  assign PCSource    = ctrl_o.pcsource;
  assign BrType      = ctrl_o.brtype;
  assign ALUOp       = ctrl_o.aluop;
  assign Illegal     = illegal_q & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised self-checking bench for multicycle_ctrl against an instruction-level model.
module tb_multicycle_ctrl;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                P_REXEC, P_RWB, P_IEXEC, P_IWB, P_BRANCH, P_JUMP} ph_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSource, BrType, ALUOp;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [5:0] cur_op;
  logic       ill_pend = 1'b0;
  logic [18:0] outv;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .BrType(BrType), .ALUOp(ALUOp), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  assign outv = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, BrType, ALUOp, Illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%05h exp=%05h", tag, $time, got, exp);
    end
  endtask

  // Expected output word for one cycle of a given instruction phase.
  function automatic logic [18:0] expv(input ph_t p, input logic mr, input logic [5:0] op,
                                       input logic ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, psrc, brt, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    {asb, psrc, brt, aop} = '0;
    case (p)
      P_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      P_DECODE: asb = 2'b11;
      P_MEMADR: begin asa = 1; asb = 2'b10; end
      P_MEMRD:  begin mrd = 1; iord = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin mwr = 1; iord = 1; end
      P_REXEC:  begin asa = 1; aop = 2'b10; end
      P_RWB:    begin rw = 1; rdst = 1; end
      P_IEXEC:  begin asa = 1; asb = 2'b10; aop = (op == 6'b001000) ? 2'b00 : 2'b11; end
      P_IWB:    rw = 1;
      P_BRANCH: begin
        asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01;
        brt = (op == 6'b000100) ? 2'b00 : (op == 6'b000101) ? 2'b01 : 2'b10;
      end
      P_JUMP:   begin pcw = 1; psrc = 2'b10; end
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, psrc, brt, aop, ill};
  endfunction

  // One clock cycle: drive inputs, compare, advance. Opcode is noise outside DECODE.
  task automatic step(input ph_t p, input logic mr);
    MemReady = mr;
    Opcode   = (p == P_DECODE) ? cur_op : 6'($urandom);
    #2;
    chk(p.name(), {13'b0, outv}, {13'b0, expv(p, mr, cur_op, ill_pend)});
    ill_pend = 1'b0;
    @(posedge clk); #1;
  endtask

  // Fetch with fw stall cycles, then the instruction's phases; memory phases stall mw cycles.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    ph_t seq[$];
    cur_op = op;
    for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0);
    step(P_FETCH, 1'b1);
    step(P_DECODE, 1'($urandom));
    case (op)
      6'b100011: seq = '{P_MEMADR, P_MEMRD, P_MEMWB};
      6'b101011: seq = '{P_MEMADR, P_MEMWR};
      6'b000000: seq = '{P_REXEC, P_RWB};
      6'b001000, 6'b001100, 6'b001101, 6'b001010: seq = '{P_IEXEC, P_IWB};
      6'b000100, 6'b000101, 6'b000111: seq = '{P_BRANCH};
      6'b000010: seq = '{P_JUMP};
      default: seq = {};
    endcase
    if (seq.size() == 0) ill_pend = 1'b1;
    foreach (seq[k]) begin
      if (seq[k] == P_MEMRD || seq[k] == P_MEMWR) begin
        for (int i = 0; i < mw; i++) step(seq[k], 1'b0);
        step(seq[k], 1'b1);
      end else begin
        step(seq[k], 1'($urandom));
      end
    end
  endtask

  logic [5:0] ops [12];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
            6'b001010, 6'b000100, 6'b000101, 6'b000111, 6'b000010, 6'b111111};
    reset = 1'b1; MemReady = 1'b1; Opcode = 6'b0; cur_op = 6'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      MemReady = 1'($urandom);
      Opcode   = 6'($urandom);
      #2;
      chk("reset_outputs", {13'b0, outv}, 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 2);
    run_instr(6'b001100, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000010, 1, 0);

    // Store interrupted by reset while the write is still pending.
    cur_op = 6'b101011;
    step(P_FETCH, 1'b1);
    step(P_DECODE, 1'b1);
    step(P_MEMADR, 1'b1);
    step(P_MEMWR, 1'b0);
    reset = 1'b1; MemReady = 1'b1;
    #2;
    chk("reset_in_memwr", {13'b0, outv}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ill_pend = 1'b0;
    run_instr(6'b000000, 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port: MemReady  input  1  memory completes the current access this cycle.
REQ-005 SHALL have ports, all outputs, 1 bit each: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA.
REQ-006 SHALL have ports, all outputs, 2 bits each: ALUSrcB (00 reg B, 01 const 4, 10 signext imm, 11 imm<<2), PCSource (00 ALU, 01 ALUOut, 10 jump), BrType (00 beq, 01 bne, 10 bgtz), ALUOp (feeds the existing ALU control decoder).
REQ-007 SHALL have port: Illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-008 SHALL be a Moore FSM; every output SHALL be a function of state and MemReady only, never of Opcode.
REQ-009 States SHALL be: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP.
REQ-010 ALUOp encoding SHALL be: 00 add (lw/sw/addi/fetch/decode), 01 subtract (branches), 10 R-type funct, 11 I-logic (andi/ori/slti).
REQ-011 FETCH SHALL drive: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-012 In FETCH, IRWrite and PCWrite SHALL equal MemReady; the FSM SHALL stay in FETCH while MemReady=0 and go to DECODE when it is 1.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, and lasts exactly one cycle.
REQ-014 DECODE next state by Opcode SHALL be:
- 100011/101011 -> MEMADR
- 000000 -> REXEC
- 001000/001100/001101/001010 -> IEXEC
- 000100/000101/000111 -> BRANCH
- 000010 -> JUMP
- any other opcode -> FETCH, with Illegal=1 for that one transition cycle.
REQ-015 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD for lw or MEMWR for sw, using the opcode held in the state register.
REQ-016 MEMRD SHALL drive MemRead=1, IorD=1, and wait while MemReady=0; MEMWR SHALL drive MemWrite=1, IorD=1, and wait while MemReady=0. MEMRD -> MEMWB on MemReady=1; MEMWR -> FETCH on MemReady=1.
REQ-017 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-018 REXEC (ALUSrcA=1, ALUSrcB=00, ALUOp=10) SHALL go to RWB; RWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-019 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, with ALUOp=00 for addi and 11 for andi/ori/slti; it goes to IWB. IWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BrType per opcode, then go to FETCH.
REQ-021 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-022 Any output not listed for a state SHALL be 0.
REQ-023 The block SHALL latch Opcode into an internal register in DECODE; states after DECODE SHALL use only the latched copy.
REQ-024 Cycle counts with MemReady tied high SHALL be: lw 5, sw 4, R-type 4, I-type 4, branch 3, jump 3.
REQ-025 Any unreachable state encoding SHALL go to FETCH on the next edge.

Reset
REQ-026 On reset=1 at a rising edge, the state SHALL become FETCH and the latched opcode 000000, regardless of the current state or any pending MemReady.
REQ-027 While reset=1, all outputs SHALL be 0. On the first cycle after reset deasserts, the FETCH outputs of REQ-011/012 SHALL apply.
REQ-028 Reset asserted mid-MEMWR SHALL deassert MemWrite in the same cycle that reset=1 is sampled.

Structure
REQ-029 Shared package mc_pkg SHALL hold: the state enum, the opcode constants, the ALUOp, ALUSrcB, PCSource and BrType constants, and one register structure shared with the ALU control decoder.
REQ-030 One sub-module SHALL be used: mc_opdecode, combinational, mapping an opcode to its class (mem/R/I/branch/jump/illegal) and to BrType. Everything else SHALL stay flat.

Verification
REQ-031 The bench SHALL cover these scenarios:
- Reset 3 cycles, then MemReady=1 with Opcode=000000 -> FETCH, DECODE, REXEC, RWB, FETCH; RegWrite=1 and RegDst=1 only in RWB; ALUOp=10 in REXEC.
- lw (100011) with MemReady low for 2 cycles in MEMRD -> MemRead held 3 cycles, IorD=1; MemtoReg=1 and RegWrite=1 exactly 1 cycle later.
- andi (001100) then addi (001000) -> ALUOp=11 then 00 in IEXEC; RegWrite pulses once each.
- bne (000101) -> BRANCH with PCWriteCond=1, PCSource=01, BrType=01, ALUOp=01; 3 cycles total.
- Opcode=111111 -> Illegal pulses 1 cycle; FSM back in FETCH; no RegWrite, MemWrite or PCWrite.
- sw with reset asserted during MEMWR -> MemWrite=0 in the reset cycle; FSM in FETCH after reset releases.
